// File: rtl/noc_output_scheduler.sv
// Output-port scheduler for a 5-port mesh router.
// Round-robin arbitration over header flits, the winner holds the link for
// the whole packet, flits move only when a downstream credit is available,
// and a stall watchdog releases a holder that stops sending mid-packet.
module noc_output_scheduler #(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [14:0] flit_ids,
    input  logic        credit_in,
    output logic [4:0]  grant,
    output logic        xfer,
    output logic [3:0]  credit_cnt,
    output logic        timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  owner;
    logic [2:0]  ptr;
    logic [7:0]  stall_cnt;

    logic [4:0]  hdr;
    logic        win_found;
    logic [2:0]  win_idx;
    logic        owner_req;
    logic [2:0]  owner_fid;
    logic [2:0]  next_ptr;

    // Ports currently presenting a header flit
    assign hdr = {req[4] & flit_ids[12],
                  req[3] & flit_ids[9],
                  req[2] & flit_ids[6],
                  req[1] & flit_ids[3],
                  req[0] & flit_ids[0]};

    // Round-robin pick: first header at or after the pointer, wrapping 4 -> 0
    always_comb begin
        logic [3:0] sum;
        logic [2:0] idx;
        win_found = 1'b0;
        win_idx   = 3'd0;
        sum       = 4'd0;
        idx       = 3'd0;
        for (int k = 0; k < 5; k++) begin
            sum = 4'(ptr) + 4'(k);
            if (sum >= 4'd5) begin
                sum = sum - 4'd5;
            end
            idx = sum[2:0];
            if (!win_found && hdr[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Request and flit id of the current link owner
    always_comb begin
        owner_req = 1'b0;
        owner_fid = 3'b000;
        case (owner)
            3'd0: begin owner_req = req[0]; owner_fid = flit_ids[2:0];   end
            3'd1: begin owner_req = req[1]; owner_fid = flit_ids[5:3];   end
            3'd2: begin owner_req = req[2]; owner_fid = flit_ids[8:6];   end
            3'd3: begin owner_req = req[3]; owner_fid = flit_ids[11:9];  end
            3'd4: begin owner_req = req[4]; owner_fid = flit_ids[14:12]; end
            default: begin owner_req = 1'b0; owner_fid = 3'b000; end
        endcase
    end

    assign xfer     = (state == GRANT) && owner_req && (credit_cnt != 4'd0);
    assign next_ptr = (owner == 3'd4) ? 3'd0 : owner + 3'd1;

    // Scheduler FSM, stall watchdog and credit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 5'd0;
            owner      <= 3'd0;
            ptr        <= 3'd0;
            credit_cnt <= 4'(CREDITS);
            stall_cnt  <= 8'd0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        grant     <= 5'd1 << win_idx;
                        owner     <= win_idx;
                        stall_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        stall_cnt <= 8'd0;
                        if (owner_fid[2]) begin
                            state <= IDLE;
                            grant <= 5'd0;
                            ptr   <= next_ptr;
                        end
                    end else if (stall_cnt == 8'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        grant   <= 5'd0;
                        ptr     <= next_ptr;
                        timeout <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 5'd0;
                end
            endcase

            if (xfer && !credit_in) begin
                credit_cnt <= credit_cnt - 4'd1;
            end else if (!xfer && credit_in && (credit_cnt != 4'(CREDITS))) begin
                credit_cnt <= credit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Bench for noc_output_scheduler: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// packet-level model of the scheduler.
module tb_noc_output_scheduler;

    localparam int CREDITS = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [2:0]  fid [5];
    logic [14:0] flit_ids;
    logic        credit_in;
    logic [4:0]  grant;
    logic        xfer;
    logic [3:0]  credit_cnt;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    assign flit_ids = {fid[4], fid[3], fid[2], fid[1], fid[0]};

    noc_output_scheduler #(.CREDITS(CREDITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_ids(flit_ids),
        .credit_in(credit_in), .grant(grant), .xfer(xfer),
        .credit_cnt(credit_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who holds the link, whose turn is next, credits left,
    // and how long the holder has been idle.
    bit m_valid = 1'b0;
    bit m_busy;
    int m_owner, m_ptr, m_credit, m_stall;
    bit m_timeout;

    // Compare outputs against the model, then advance it by one clock
    always @(negedge clk) begin
        bit ex;
        bit t;
        bit found;
        int eg;
        int idx;
        ex = m_valid && m_busy && req[m_owner] && (m_credit != 0);
        eg = m_busy ? (1 << m_owner) : 0;
        if (m_valid) begin
            chk("model_grant", int'(grant), eg);
            chk("model_xfer", int'(xfer), int'(ex));
            chk("model_credit", int'(credit_cnt), m_credit);
            chk("model_timeout", int'(timeout), int'(m_timeout));
            chk("grant_onehot0", int'($onehot0(grant)), 1);
        end
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_owner = 0; m_ptr = 0;
            m_credit = CREDITS; m_stall = 0; m_timeout = 1'b0;
        end else if (m_valid) begin
            t = 1'b0;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    idx = (m_ptr + k) % 5;
                    if (!found && req[idx] && fid[idx][0]) begin
                        found = 1'b1; m_busy = 1'b1; m_owner = idx; m_stall = 0;
                    end
                end
            end else if (ex) begin
                m_stall = 0;
                if (fid[m_owner][2]) begin
                    m_busy = 1'b0; m_ptr = (m_owner + 1) % 5;
                end
            end else if (m_stall == TIMEOUT - 1) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % 5; t = 1'b1;
            end else begin
                m_stall++;
            end
            if (ex && !credit_in) m_credit--;
            else if (!ex && credit_in && m_credit < CREDITS) m_credit++;
            m_timeout = t;
        end
    end

    initial begin
        logic [2:0] ftab [4];
        int dens;
        ftab[0] = 3'b001; ftab[1] = 3'b010; ftab[2] = 3'b100; ftab[3] = 3'b101;
        rst = 1'b1; req = 5'd0; credit_in = 1'b0;
        for (int i = 0; i < 5; i++) fid[i] = 3'b000;
        step(); step();

        // Single-flit packet right after reset
        rst = 1'b0; req = 5'b00001; fid[0] = 3'b101; #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_credit", int'(credit_cnt), 4);
        chk("rst_timeout", int'(timeout), 0);
        chk("idle_xfer", int'(xfer), 0);
        step(); #1;
        chk("single_grant", int'(grant), 1);
        chk("single_xfer", int'(xfer), 1);
        step(); req = 5'd0; #1;
        chk("single_release", int'(grant), 0);
        chk("single_credit", int'(credit_cnt), 3);

        // Round robin over five 3-flit packets, credits returned on each xfer
        rst = 1'b1; step(); rst = 1'b0;
        req = 5'b11111;
        for (int i = 0; i < 5; i++) fid[i] = 3'b001;
        for (int g = 0; g < 6; g++) begin
            int p;
            p = g % 5;
            #1;
            chk("rr_idle_grant", int'(grant), 0);
            chk("rr_idle_xfer", int'(xfer), 0);
            step(); credit_in = 1'b1; #1;
            chk("rr_grant_hdr", int'(grant), 1 << p);
            chk("rr_xfer_hdr", int'(xfer), 1);
            step(); fid[p] = 3'b010; #1;
            chk("rr_grant_body", int'(grant), 1 << p);
            chk("rr_xfer_body", int'(xfer), 1);
            step(); fid[p] = 3'b100; #1;
            chk("rr_grant_tail", int'(grant), 1 << p);
            chk("rr_xfer_tail", int'(xfer), 1);
            chk("rr_credit", int'(credit_cnt), 4);
            step(); fid[p] = 3'b001; credit_in = 1'b0;
        end

        // Credit starvation on port E
        req = 5'b00100; fid[2] = 3'b001; #1;
        chk("starve_idle", int'(grant), 0);
        step(); #1;
        chk("starve_grant", int'(grant), 5'b00100);
        chk("starve_x1", int'(xfer), 1);
        step(); fid[2] = 3'b010; #1;
        chk("starve_c3", int'(credit_cnt), 3);
        step(); #1;
        chk("starve_c2", int'(credit_cnt), 2);
        step(); #1;
        chk("starve_c1", int'(credit_cnt), 1);
        chk("starve_x4", int'(xfer), 1);
        step(); #1;
        chk("starve_c0", int'(credit_cnt), 0);
        chk("starve_noxfer", int'(xfer), 0);
        chk("starve_hold", int'(grant), 5'b00100);
        step(); step(); credit_in = 1'b1; #1;
        chk("starve_still", int'(xfer), 0);
        step(); credit_in = 1'b0; #1;
        chk("starve_one_credit", int'(credit_cnt), 1);
        chk("starve_one_xfer", int'(xfer), 1);
        step(); #1;
        chk("starve_only_one", int'(xfer), 0);

        // Simultaneous credit_in and xfer, then saturation
        req = 5'd0; credit_in = 1'b1;
        step(); step();
        req = 5'b00100; fid[2] = 3'b100; #1;
        chk("sim_pre_credit", int'(credit_cnt), 2);
        chk("sim_xfer", int'(xfer), 1);
        step(); credit_in = 1'b0; req = 5'd0; #1;
        chk("sim_credit", int'(credit_cnt), 2);
        chk("sim_release", int'(grant), 0);
        credit_in = 1'b1;
        step(); step(); #1;
        chk("sat_pre", int'(credit_cnt), 4);
        step(); credit_in = 1'b0; #1;
        chk("sat_credit", int'(credit_cnt), 4);

        // Watchdog: W sends its header then goes silent, S waits behind it
        req = 5'b11000; fid[3] = 3'b001; fid[4] = 3'b001; #1;
        chk("wd_idle", int'(grant), 0);
        step(); #1;
        chk("wd_grant", int'(grant), 5'b01000);
        chk("wd_hdr_xfer", int'(xfer), 1);
        step(); req[3] = 1'b0; fid[3] = 3'b010;
        for (int k = 0; k < TIMEOUT; k++) begin
            #1;
            chk("wd_hold", int'(grant), 5'b01000);
            chk("wd_no_pulse", int'(timeout), 0);
            step();
        end
        #1;
        chk("wd_release", int'(grant), 0);
        chk("wd_pulse", int'(timeout), 1);
        step(); #1;
        chk("wd_next_s", int'(grant), 5'b10000);
        chk("wd_pulse_once", int'(timeout), 0);
        chk("wd_s_xfer", int'(xfer), 1);

        // Body flit in IDLE is ignored, then reset mid-packet
        step(); fid[4] = 3'b100; #1;
        chk("s_tail_xfer", int'(xfer), 1);
        step(); req = 5'b00010; fid[1] = 3'b010; fid[4] = 3'b001; #1;
        chk("nonhdr_0", int'(grant), 0);
        step(); #1;
        chk("nonhdr_1", int'(grant), 0);
        step(); fid[1] = 3'b001;
        step(); #1;
        chk("midpkt_grant", int'(grant), 5'b00010);
        rst = 1'b1; req = 5'd0;
        step(); rst = 1'b0; #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_credit", int'(credit_cnt), 4);
        req = 5'b11111;
        for (int i = 0; i < 5; i++) fid[i] = 3'b001;
        step(); #1;
        chk("midrst_ptr", int'(grant), 5'b00001);
        req = 5'd0;
        step();

        // Randomized traffic checked by the model
        dens = 5;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) dens = int'($urandom_range(1, 9));
            for (int i = 0; i < 5; i++) begin
                req[i] = ($urandom_range(0, 9) < dens);
                fid[i] = ftab[$urandom_range(0, 3)];
            end
            credit_in = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; req = 5'd0; credit_in = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_output_scheduler.md
Name: noc_output_scheduler

Overview:
- Per-output-port scheduler for the 5-port mesh router (L, N, E, W, S inputs).
- Shares one output link among the five input ports using round-robin arbitration with packet-level locking: once a header wins, that port holds the link until its tail flit leaves.
- Tracks downstream buffer credits and transfers a flit only when a credit is available.
- A stall watchdog releases the link if the holder stops sending mid-packet.

Parameters:
- CREDITS, 4, downstream buffer depth and reset value of the credit counter (1..15).
- TIMEOUT, 16, consecutive stalled cycles in GRANT before forced release (1..255).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  5  per-port flit-valid request; bit0=L, 1=N, 2=E, 3=W, 4=S
- flit_ids  in  15  per-port 3-bit flit_id; port i uses bits [3i+2:3i]; 001 header, 010 body, 100 tail, 101 single-flit (header+tail)
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot
- grant  out  5  registered one-hot owner of the link; 0 when idle
- xfer  out  1  combinational: a flit from the grant owner moves this cycle
- credit_cnt  out  4  current credit count
- timeout  out  1  registered one-cycle pulse on forced release

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, grant=0, pointer=0 (L), credit_cnt=CREDITS, stall count=0, timeout=0. A reset mid-packet abandons the packet; no flit is counted.
- State IDLE:
  - Candidates are ports i with req[i]=1 and flit_id[i][0]=1 (header).
  - Requests whose flit_id is body or tail are ignored in IDLE.
  - Winner = first candidate at or after the pointer, scanning upward and wrapping 4 -> 0.
  - If there is a winner: next edge sets grant to that port's one-hot and moves to GRANT. The grant goes out even when credit_cnt=0.
  - No transfer occurs in IDLE; xfer=0.
- State GRANT, owner p:
  - xfer = req[p] and credit_cnt != 0.
  - On xfer with flit_id[p][2]=1 (tail or single-flit): next edge goes to IDLE, grant=0, pointer=(p+1) mod 5.
  - On xfer without a tail bit: stay in GRANT and clear the stall count.
  - When xfer=0: stall count increments.
  - When the stall count reaches TIMEOUT-1 and the cycle is still stalled: next edge goes to IDLE, grant=0, pointer=(p+1) mod 5, timeout=1 for one cycle.
  - Requests from other ports have no effect while in GRANT.
- Arbitration latency:
  - A header presented in IDLE is granted on the next edge.
  - Its first transfer happens in the cycle after that, provided credit is available.
  - Back-to-back packets incur exactly one IDLE cycle between tail xfer and the next grant.
- Credits:
  - xfer only: credit_cnt decrements.
  - credit_in only: credit_cnt increments.
  - xfer and credit_in in the same cycle: credit_cnt unchanged.
  - credit_in while credit_cnt=CREDITS: ignored, count saturates.
  - xfer cannot happen at 0, so there is no underflow.
- Stall count is 8 bits, cleared on every xfer and on every entry to GRANT.
- grant is one-hot or zero at all times; at most one xfer per cycle.

Test Plan:
- Reset then single-flit packet:
  - Stimulus: rst 2 cycles; req=00001, flit_ids[2:0]=101.
  - Response: grant=00001 one edge later; xfer=1 the next cycle; credit_cnt 4->3; return to IDLE; pointer=1.
- Round-robin fairness:
  - Stimulus: req=11111 with all headers, each packet 3 flits (001, 010, 100), credit_in pulsed on every xfer.
  - Response: grant order L, N, E, W, S, L; 3 xfers per grant; one idle cycle between grants.
- Credit starvation:
  - Stimulus: CREDITS=4, port E sends a 6-flit packet, no credit_in.
  - Response: 4 xfers, then credit_cnt=0 and xfer=0 with grant held at 00100; a later credit_in gives exactly one more xfer.
- Simultaneous credit_in and xfer:
  - Stimulus: credit_cnt=2, xfer and credit_in in the same cycle.
  - Response: credit_cnt stays 2.
  - Follow-up stimulus: credit_in at credit_cnt=4.
  - Follow-up response: credit_cnt stays 4.
- Watchdog:
  - Stimulus: TIMEOUT=16; port W sends a header, then req[3] drops for 20 cycles.
  - Response: after 16 stalled cycles, grant->0 and timeout pulses once; pointer=4; port S header granted next.
- Non-header in IDLE and reset mid-packet:
  - Stimulus 1: req=00010 with flit_id 010 in IDLE.
  - Response 1: no grant.
  - Stimulus 2: rst asserted while in GRANT.
  - Response 2: grant=0, credit_cnt=4, pointer=0 on the next edge.
